// File: rtl/recovery_restore_seq_if.sv
// ============================================================================
// Module   : recovery_restore_seq_if
// Purpose  : Bundles the restore request, recovery-bank read port and core
//            register-file write port of recovery_restore_seq.
//            Checksum signals exist only when RESTORE_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface recovery_restore_seq_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              restore_req;
  logic [31:0]       rec_addr;
  logic [DATA_W-1:0] rec_rd;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wd;
  logic              core_stall;
  logic              restore_busy;
  logic              restore_done;
`ifdef RESTORE_CHECKSUM_EN
  logic [DATA_W-1:0] exp_checksum;
  logic              chk_err;
`endif

  // Sequencer side
  modport master (
`ifdef RESTORE_CHECKSUM_EN
    input  exp_checksum,
    output chk_err,
`endif
    input  restore_req,
    input  rec_rd,
    output rec_addr,
    output rf_we,
    output rf_addr,
    output rf_wd,
    output core_stall,
    output restore_busy,
    output restore_done
  );

  // Controller / register-bank / register-file side
  modport slave (
`ifdef RESTORE_CHECKSUM_EN
    output exp_checksum,
    input  chk_err,
`endif
    output restore_req,
    output rec_rd,
    input  rec_addr,
    input  rf_we,
    input  rf_addr,
    input  rf_wd,
    input  core_stall,
    input  restore_busy,
    input  restore_done
  );
endinterface

`default_nettype wire

// File: rtl/recovery_restore_seq.sv
// ============================================================================
// Module   : recovery_restore_seq
// Purpose  : Walks recovery register entries 1..NUM_REGS-1 after a fault and
//            writes each saved word back into the core register file while
//            stalling the core. Entry 0 (x0) is never restored.
//            Optional: RESTORE_CHECKSUM_EN adds an XOR checksum of the
//            restored words compared against exp_checksum (chk_err).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module recovery_restore_seq #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
) (
  input  wire logic               clk,
  input  wire logic               rst_in,
  recovery_restore_seq_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;
  logic [DATA_W-1:0] data_q;
  logic [31:0]       rec_addr_q;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic              busy_q;
  logic              done_q;

  assign idx_d = idx_q + FIRST_IDX;

  // Restore sequencer: state, index and every output are registered together
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      idx_q      <= FIRST_IDX;
      data_q     <= '0;
      rec_addr_q <= '0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.restore_req) begin
            state_q    <= S_READ;
            idx_q      <= FIRST_IDX;
            rec_addr_q <= {{(32-ADDR_W){1'b0}}, FIRST_IDX};
            busy_q     <= 1'b1;
          end
        end
        S_READ: begin
          // Only sampling point of the combinational read data
          data_q    <= bus.rec_rd;
          rf_we_q   <= 1'b1;
          rf_addr_q <= idx_q;
          state_q   <= S_WRITE;
        end
        S_WRITE: begin
          rf_we_q   <= 1'b0;
          rf_addr_q <= '0;
          if (idx_q == LAST_IDX) begin
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            rec_addr_q <= '0;
          end else begin
            idx_q      <= idx_d;
            rec_addr_q <= {{(32-ADDR_W){1'b0}}, idx_d};
            state_q    <= S_READ;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rec_addr     = rec_addr_q;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_addr      = rf_addr_q;
  assign bus.rf_wd        = data_q;
  assign bus.core_stall   = busy_q;
  assign bus.restore_busy = busy_q;
  assign bus.restore_done = done_q;

`ifdef RESTORE_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q;
  logic              chk_err_q;

  // XOR of every latched word; verdict taken while in DONE, held until next accept
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      acc_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.restore_req) begin
            acc_q     <= '0;
            chk_err_q <= 1'b0;
          end
        end
        S_READ: acc_q <= acc_q ^ bus.rec_rd;
        S_DONE: chk_err_q <= (acc_q != bus.exp_checksum);
        default: begin
          acc_q <= acc_q;
        end
      endcase
    end
  end

  assign bus.chk_err = chk_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_recovery_restore_seq.sv
// ============================================================================
// Module   : tb_recovery_restore_seq
// Purpose  : Directed + randomized self-checking bench for recovery_restore_seq.
//            Expected behaviour is derived from the cycle schedule of a restore
//            (entry k read in cycle 2k-1, written in cycle 2k, done in 63).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_recovery_restore_seq;
  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;

  logic clk = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk = ~clk;

  recovery_restore_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  recovery_restore_seq #(
    .NUM_REGS(NUM_REGS),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_in(rst_in),
    .bus   (bus)
  );

  // Recovery register bank model (combinational read) and golden contents
  logic [DATA_W-1:0] mem  [NUM_REGS];
  logic [DATA_W-1:0] gold [NUM_REGS];
  assign bus.rec_rd = (bus.rec_addr < NUM_REGS) ? mem[bus.rec_addr[ADDR_W-1:0]] : '0;

  int checks = 0;
  int errors = 0;
  bit chk_now = 1'b0;   // chk_err value expected while idle
  bit chk_result = 1'b0; // chk_err value expected once the running restore ends

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] xor_gold();
    logic [DATA_W-1:0] x;
    x = '0;
    for (int i = 1; i < NUM_REGS; i++) x = x ^ gold[i];
    return x;
  endfunction

  // Copy golden data into the bank; checksum input set to the true XOR
  task automatic load_bank();
    for (int i = 0; i < NUM_REGS; i++) mem[i] = gold[i];
`ifdef RESTORE_CHECKSUM_EN
    bus.exp_checksum = xor_gold();
`endif
  endtask

  task automatic randomize_gold();
    for (int i = 0; i < NUM_REGS; i++) gold[i] = $urandom;
    gold[0] = 32'hFFFF_FFFF;
  endtask

  task automatic check_idle(string tag);
    check({tag, " busy"}, 64'(bus.restore_busy), 64'd0);
    check({tag, " stall"}, 64'(bus.core_stall), 64'd0);
    check({tag, " we"}, 64'(bus.rf_we), 64'd0);
    check({tag, " done"}, 64'(bus.restore_done), 64'd0);
    check({tag, " rec_addr"}, 64'(bus.rec_addr), 64'd0);
`ifdef RESTORE_CHECKSUM_EN
    check({tag, " chk_err"}, 64'(bus.chk_err), 64'(chk_now));
`endif
  endtask

  // Checks one cycle c (1..64) counted from the accepting edge
  task automatic check_cycle(int c);
    bit w;
    int k;
    w = (c >= 2) && (c <= 2 * (NUM_REGS - 1)) && (c % 2 == 0);
    k = (c + 1) / 2;
    if (w) begin
      // Disturb the read data during WRITE: the written word must not follow it
      mem[k] = ~gold[k];
      #1;
    end
    check($sformatf("busy c%0d", c), 64'(bus.restore_busy), 64'(c <= 63));
    check($sformatf("stall c%0d", c), 64'(bus.core_stall), 64'(c <= 63));
    check($sformatf("done c%0d", c), 64'(bus.restore_done), 64'(c == 63));
    check($sformatf("we c%0d", c), 64'(bus.rf_we), 64'(w));
    if (w) begin
      check($sformatf("rf_addr c%0d", c), 64'(bus.rf_addr), 64'(k));
      check($sformatf("rf_wd c%0d", c), 64'(bus.rf_wd), 64'(gold[k]));
      mem[k] = gold[k];
    end
    if (c <= 62) check($sformatf("rec_addr c%0d", c), 64'(bus.rec_addr), 64'(k));
    if (c == 64) check("rec_addr idle", 64'(bus.rec_addr), 64'd0);
`ifdef RESTORE_CHECKSUM_EN
    check($sformatf("chk_err c%0d", c), 64'(bus.chk_err), 64'((c == 64) ? chk_result : 1'b0));
`endif
  endtask

  // n restores; hold keeps req high; req_at pulses req in that cycle;
  // rst_at asserts reset in that cycle and abandons the restore
  task automatic run_restore(int n, bit hold, int req_at, int rst_at);
`ifdef RESTORE_CHECKSUM_EN
    chk_result = (xor_gold() != bus.exp_checksum);
`endif
    bus.restore_req = 1'b1;
    tick();
    if (!hold) bus.restore_req = 1'b0;
    for (int r = 0; r < n; r++) begin
      for (int c = 1; c <= 64; c++) begin
        check_cycle(c);
        if (rst_at == c) begin
          rst_in = 1'b1;
          #1;
          chk_now = 1'b0;
          check("rst we", 64'(bus.rf_we), 64'd0);
          check("rst busy", 64'(bus.restore_busy), 64'd0);
          check("rst stall", 64'(bus.core_stall), 64'd0);
          check("rst rec_addr", 64'(bus.rec_addr), 64'd0);
          tick();
          rst_in = 1'b0;
          bus.restore_req = 1'b0;
          return;
        end
        if (req_at == c) bus.restore_req = 1'b1;
        else if (!hold) bus.restore_req = 1'b0;
        if (c < 64 || r < n - 1) tick();
      end
    end
    bus.restore_req = 1'b0;
    chk_now = chk_result;
  endtask

  initial begin
    bus.restore_req = 1'b0;
`ifdef RESTORE_CHECKSUM_EN
    bus.exp_checksum = '0;
`endif
    for (int i = 0; i < NUM_REGS; i++) begin
      gold[i] = '0;
      mem[i]  = '0;
    end

    // Reset state
    tick();
    tick();
    check_idle("reset");
    rst_in = 1'b0;
    tick();
    check_idle("post-reset");

    // Fixed pattern, entry 0 all ones
    for (int i = 0; i < NUM_REGS; i++) gold[i] = 32'hA5A5_0000 + 32'(i);
    gold[0] = 32'hFFFF_FFFF;
    load_bank();
    run_restore(1, 1'b0, 0, 0);
    tick();
    check_idle("t1 idle");

    // Request held high: back-to-back restores with one idle cycle between
    randomize_gold();
    load_bank();
    run_restore(3, 1'b1, 0, 0);
    tick();
    check_idle("t2 idle");

    // Request during WRITE of entry 10 is ignored
    randomize_gold();
    load_bank();
    run_restore(1, 1'b0, 20, 0);
    tick();
    check_idle("t3 idle");

    // Request during DONE is ignored and not queued
    run_restore(1, 1'b0, 63, 0);
    tick();
    check_idle("t3b idle1");
    tick();
    check_idle("t3b idle2");

    // Reset during WRITE of entry 15, then a full restart from entry 1
    randomize_gold();
    load_bank();
    run_restore(1, 1'b0, 0, 30);
    check_idle("t4 after rst");
    run_restore(1, 1'b0, 0, 0);
    tick();
    check_idle("t4 idle");

    // Checksum: good, corrupted entry 7 bit 3, then good again (clears)
    randomize_gold();
    load_bank();
    run_restore(1, 1'b0, 0, 0);
    tick();
    check_idle("t6 good");
    gold[7] = gold[7] ^ 32'h0000_0008;
    mem[7]  = gold[7];
    run_restore(1, 1'b0, 0, 0);
    tick();
    check_idle("t6 bad");
    tick();
    check_idle("t6 bad hold");
    gold[7] = gold[7] ^ 32'h0000_0008;
    mem[7]  = gold[7];
    run_restore(1, 1'b0, 0, 0);
    tick();
    check_idle("t6 cleared");

    // Random restores
    for (int t = 0; t < 3; t++) begin
      randomize_gold();
      load_bank();
      run_restore(1, 1'b0, 0, 0);
      tick();
      check_idle("rand idle");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
